// File: rtl/bp_lce_mem_arbiter_if.sv
// Bundles the requester and memory handshake signals of bp_lce_mem_arbiter.
//   slave  : the arbiter's view (request inputs, yumi/data outputs, memory side).
//   master : the environment's view (cache, LCE and memory models).
// Signal names keep the arbiter-relative _i/_o suffixes of the original ports.
interface bp_lce_mem_arbiter_if #(
    parameter int pkt_width_p  = 8,
    parameter int data_width_p = 8
);
    logic                    cache_pkt_v_i;
    logic [pkt_width_p-1:0]  cache_pkt_i;
    logic                    cache_pkt_read_i;
    logic                    cache_pkt_yumi_o;
    logic                    cache_data_v_o;
    logic [data_width_p-1:0] cache_data_o;
    logic                    cache_stall_o;

    logic                    lce_pkt_v_i;
    logic [pkt_width_p-1:0]  lce_pkt_i;
    logic                    lce_pkt_read_i;
    logic                    lce_pkt_yumi_o;
    logic                    lce_data_v_o;
    logic [data_width_p-1:0] lce_data_o;

    logic                    mem_pkt_v_o;
    logic [pkt_width_p-1:0]  mem_pkt_o;
    logic                    mem_pkt_yumi_i;
    logic [data_width_p-1:0] mem_data_i;

    modport slave (
        input  cache_pkt_v_i, cache_pkt_i, cache_pkt_read_i,
        output cache_pkt_yumi_o, cache_data_v_o, cache_data_o, cache_stall_o,
        input  lce_pkt_v_i, lce_pkt_i, lce_pkt_read_i,
        output lce_pkt_yumi_o, lce_data_v_o, lce_data_o,
        output mem_pkt_v_o, mem_pkt_o,
        input  mem_pkt_yumi_i, mem_data_i
    );

    modport master (
        output cache_pkt_v_i, cache_pkt_i, cache_pkt_read_i,
        input  cache_pkt_yumi_o, cache_data_v_o, cache_data_o, cache_stall_o,
        output lce_pkt_v_i, lce_pkt_i, lce_pkt_read_i,
        input  lce_pkt_yumi_o, lce_data_v_o, lce_data_o,
        input  mem_pkt_v_o, mem_pkt_o,
        output mem_pkt_yumi_i, mem_data_i
    );
endinterface

// File: rtl/bp_lce_mem_arbiter.sv
// Arbitrates one single-ported cache memory between the cache pipeline and
// the LCE. The cache has priority until the LCE has waited
// timeout_max_limit_p cycles; then the LCE is forced through and the cache
// is stalled. Read data (one cycle after acceptance) is passed through and
// only the valid is steered to the requester that issued the read.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   bus        requester/memory handshake bundle (slave modport)
module bp_lce_mem_arbiter #(
    parameter int pkt_width_p         = 8,
    parameter int data_width_p        = 8,
    parameter int timeout_max_limit_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_lce_mem_arbiter_if.slave   bus
);
    localparam int cnt_width_lp = $clog2(timeout_max_limit_p + 1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(timeout_max_limit_p);

    typedef enum logic {
        e_cache_pri,
        e_lce_pri
    } state_e;

    state_e                  state_r;
    logic                    stall_r;
    logic [cnt_width_lp-1:0] wait_cnt_r;
    logic                    rd_v_r;
    logic                    rd_owner_r;

    logic                    grant_lce;
    logic                    mem_v;
    logic                    accept;
    logic                    granted_read;
    logic                    lce_yumi;
    logic [pkt_width_p-1:0]  granted_pkt;
    logic [data_width_p-1:0] rd_data;

    always_comb begin
        grant_lce    = bus.lce_pkt_v_i & ((state_r == e_lce_pri) | ~bus.cache_pkt_v_i);
        mem_v        = bus.cache_pkt_v_i | bus.lce_pkt_v_i;
        accept       = mem_v & bus.mem_pkt_yumi_i;
        lce_yumi     = accept & grant_lce;
        granted_read = grant_lce ? bus.lce_pkt_read_i : bus.cache_pkt_read_i;
        granted_pkt  = grant_lce ? bus.lce_pkt_i : bus.cache_pkt_i;
        rd_data      = bus.mem_data_i;
    end

    assign bus.mem_pkt_v_o      = mem_v;
    assign bus.mem_pkt_o        = granted_pkt;
    assign bus.cache_pkt_yumi_o = accept & ~grant_lce;
    assign bus.lce_pkt_yumi_o   = lce_yumi;
    assign bus.cache_stall_o    = stall_r;
    assign bus.cache_data_v_o   = rd_v_r & ~rd_owner_r;
    assign bus.lce_data_v_o     = rd_v_r & rd_owner_r;
    assign bus.cache_data_o     = rd_data;
    assign bus.lce_data_o       = rd_data;

    // stall_r mirrors the e_lce_pri state so the stall output is a flop.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_cache_pri;
            stall_r    <= 1'b0;
            wait_cnt_r <= '0;
            rd_v_r     <= 1'b0;
            rd_owner_r <= 1'b0;
        end else begin
            case (state_r)
                e_cache_pri: begin
                    if ((wait_cnt_r == cnt_max_lp) && bus.lce_pkt_v_i) begin
                        state_r <= e_lce_pri;
                        stall_r <= 1'b1;
                    end
                end
                e_lce_pri: begin
                    if (lce_yumi || !bus.lce_pkt_v_i) begin
                        state_r <= e_cache_pri;
                        stall_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= e_cache_pri;
                    stall_r <= 1'b0;
                end
            endcase

            if (!bus.lce_pkt_v_i || lce_yumi)
                wait_cnt_r <= '0;
            else if (wait_cnt_r != cnt_max_lp)
                wait_cnt_r <= wait_cnt_r + 1'b1;

            rd_v_r <= accept & granted_read;
            if (accept && granted_read)
                rd_owner_r <= grant_lce;
        end
    end
endmodule
